// File: rtl/int_action_arbiter_pkg.sv
// Shared widths, FSM encodings and command-length codes for the interrupt action arbiter.
package int_action_arbiter_pkg;

    localparam int unsigned FUNC_WIDTH = 4;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned PAYLOAD_W  = 3 * DATA_WIDTH;
    localparam int unsigned IDX_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_REQ  = 2'b10,
        ST_GAP  = 2'b11
    } state_e;

    typedef logic [1:0] cmd_len_t;

    localparam cmd_len_t CMD_LEN_WAKE = 2'b00;
    localparam cmd_len_t CMD_LEN_1    = 2'b01;
    localparam cmd_len_t CMD_LEN_2    = 2'b10;
    localparam cmd_len_t CMD_LEN_3    = 2'b11;

    // Zero payload words beyond the command length; word0 is the MSB word.
    function automatic logic [PAYLOAD_W-1:0] mask_payload(
        input logic [PAYLOAD_W-1:0] payload,
        input cmd_len_t             len
    );
        logic [PAYLOAD_W-1:0] result;
        result = '0;
        case (len)
            CMD_LEN_1: result = {payload[PAYLOAD_W-1 -: DATA_WIDTH], (2*DATA_WIDTH)'(0)};
            CMD_LEN_2: result = {payload[PAYLOAD_W-1 -: 2*DATA_WIDTH], DATA_WIDTH'(0)};
            CMD_LEN_3: result = payload;
            default:   result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/int_action_arbiter_if.sv
// ROM fields, request pulses and the command handshake between the arbiter and its neighbours.
interface int_action_arbiter_if
    import int_action_arbiter_pkg::*;
#(
    parameter int unsigned LC_INT_DEPTH = 8
);

    logic [LC_INT_DEPTH-1:0]            INT_VECTOR;
    logic [FUNC_WIDTH*LC_INT_DEPTH-1:0] ROM_FUNC_ID;
    logic [PAYLOAD_W*LC_INT_DEPTH-1:0]  ROM_PAYLOAD;
    logic [2*LC_INT_DEPTH-1:0]          ROM_CMD_LEN;

    logic                               INT_REQ;
    logic [FUNC_WIDTH-1:0]              INT_FUNC_ID;
    logic [PAYLOAD_W-1:0]               INT_PAYLOAD;
    logic [1:0]                         INT_CMD_LEN;
    logic [IDX_W-1:0]                   INT_IDX;
    logic                               INT_ACK;
    logic                               WAKEUP_REQ;
    logic [LC_INT_DEPTH-1:0]            CLR_INT;
    logic [LC_INT_DEPTH-1:0]            PENDING;

    // Arbiter side: issues commands toward the layer controller.
    modport master (
        input  INT_VECTOR, ROM_FUNC_ID, ROM_PAYLOAD, ROM_CMD_LEN, INT_ACK,
        output INT_REQ, INT_FUNC_ID, INT_PAYLOAD, INT_CMD_LEN, INT_IDX,
               WAKEUP_REQ, CLR_INT, PENDING
    );

    // Environment side: interrupt sources, action ROM and command engine.
    modport slave (
        output INT_VECTOR, ROM_FUNC_ID, ROM_PAYLOAD, ROM_CMD_LEN, INT_ACK,
        input  INT_REQ, INT_FUNC_ID, INT_PAYLOAD, INT_CMD_LEN, INT_IDX,
               WAKEUP_REQ, CLR_INT, PENDING
    );

endinterface

// File: rtl/int_prio_enc.sv
// Combinational lowest-set-bit priority encoder with a valid flag.
module int_prio_enc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 4
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_valid_c
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx_c   = IDX_W'(i);
                o_valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_action_arbiter.sv
// Latches interrupt pulses, services the lowest pending vector from the action ROM and
// presents it over REQ/ACK; length-0 vectors only raise a wake pulse.
module int_action_arbiter
    import int_action_arbiter_pkg::*;
#(
    parameter int unsigned LC_INT_DEPTH = 8
) (
    input logic                   CLK,
    input logic                   RESET,
    int_action_arbiter_if.master  bus
);

    localparam int unsigned SEL_W = (LC_INT_DEPTH > 1) ? $clog2(LC_INT_DEPTH) : 1;

    state_e                  r_state;
    logic [LC_INT_DEPTH-1:0] r_pending;
    logic [IDX_W-1:0]        r_sel;
    logic                    r_req;
    logic [FUNC_WIDTH-1:0]   r_func_id;
    logic [PAYLOAD_W-1:0]    r_payload;
    cmd_len_t                r_cmd_len;
    logic                    r_wakeup;
    logic [LC_INT_DEPTH-1:0] r_clr;

    logic [IDX_W-1:0]        w_enc_idx;
    logic                    w_enc_valid;
    logic [LC_INT_DEPTH-1:0] w_sel_onehot;
    logic [LC_INT_DEPTH-1:0] w_clr_mask;
    logic [FUNC_WIDTH-1:0]   w_cur_func;
    logic [PAYLOAD_W-1:0]    w_cur_payload;
    cmd_len_t                w_cur_len;
    logic                    w_retire;

    logic [FUNC_WIDTH-1:0]   w_rom_func    [LC_INT_DEPTH];
    logic [PAYLOAD_W-1:0]    w_rom_payload [LC_INT_DEPTH];
    cmd_len_t                w_rom_len     [LC_INT_DEPTH];

    // Slice the flattened ROM buses into per-vector fields.
    for (genvar gi = 0; gi < LC_INT_DEPTH; gi++) begin : g_rom_field
        assign w_rom_func[gi]    = bus.ROM_FUNC_ID[gi*FUNC_WIDTH +: FUNC_WIDTH];
        assign w_rom_payload[gi] = bus.ROM_PAYLOAD[gi*PAYLOAD_W +: PAYLOAD_W];
        assign w_rom_len[gi]     = bus.ROM_CMD_LEN[gi*2 +: 2];
    end

    int_prio_enc #(
        .WIDTH (LC_INT_DEPTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .i_req     (r_pending),
        .o_idx_c   (w_enc_idx),
        .o_valid_c (w_enc_valid)
    );

    assign w_cur_func    = w_rom_func[r_sel[SEL_W-1:0]];
    assign w_cur_payload = w_rom_payload[r_sel[SEL_W-1:0]];
    assign w_cur_len     = w_rom_len[r_sel[SEL_W-1:0]];
    assign w_sel_onehot  = LC_INT_DEPTH'(1) << r_sel;

    // A vector retires on a wake-only load or on the command engine's accept.
    assign w_retire   = ((r_state == ST_LOAD) && (w_cur_len == CMD_LEN_WAKE)) ||
                        ((r_state == ST_REQ) && bus.INT_ACK);
    assign w_clr_mask = w_retire ? w_sel_onehot : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_sel     <= '0;
            r_req     <= 1'b0;
            r_func_id <= '0;
            r_payload <= '0;
            r_cmd_len <= CMD_LEN_WAKE;
            r_wakeup  <= 1'b0;
            r_clr     <= '0;
        end else begin
            // A set arriving with a clear on the same bit wins, so the vector is re-serviced.
            r_pending <= (r_pending & ~w_clr_mask) | bus.INT_VECTOR;
            r_clr     <= w_clr_mask;
            r_wakeup  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_enc_valid) begin
                        r_sel   <= w_enc_idx;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_cur_len == CMD_LEN_WAKE) begin
                        r_wakeup <= 1'b1;
                        r_state  <= ST_GAP;
                    end else begin
                        r_func_id <= w_cur_func;
                        r_payload <= mask_payload(w_cur_payload, w_cur_len);
                        r_cmd_len <= w_cur_len;
                        r_req     <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Command fields return to zero once accepted.
                    if (bus.INT_ACK) begin
                        r_req     <= 1'b0;
                        r_func_id <= '0;
                        r_payload <= '0;
                        r_cmd_len <= CMD_LEN_WAKE;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.INT_REQ     = r_req;
    assign bus.INT_FUNC_ID = r_func_id;
    assign bus.INT_PAYLOAD = r_payload;
    assign bus.INT_CMD_LEN = r_cmd_len;
    assign bus.INT_IDX     = r_sel;
    assign bus.WAKEUP_REQ  = r_wakeup;
    assign bus.CLR_INT     = r_clr;
    assign bus.PENDING     = r_pending;

endmodule

// File: tb/tb_int_action_arbiter.sv
// Directed bench for int_action_arbiter with hand-computed expectations.
module tb_int_action_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    int_action_arbiter_if #(.LC_INT_DEPTH(8)) bus ();

    int_action_arbiter #(.LC_INT_DEPTH(8)) u_dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rom(input int idx, input logic [3:0] f, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2, input logic [1:0] len);
        bus.ROM_FUNC_ID[idx*4 +: 4]   = f;
        bus.ROM_PAYLOAD[idx*96 +: 96] = {w0, w1, w2};
        bus.ROM_CMD_LEN[idx*2 +: 2]   = len;
    endtask

    task automatic pulse_vec(input logic [7:0] v);
        bus.INT_VECTOR = v;
        tick();
        bus.INT_VECTOR = 8'h00;
    endtask

    task automatic wait_req(input int max_cyc);
        int n;
        n = 0;
        while (!bus.INT_REQ && n < max_cyc) begin
            tick();
            n++;
        end
        check("req_timeout", 96'(bus.INT_REQ), 96'd1);
    endtask

    task automatic ack(input logic [7:0] exp_clr);
        bus.INT_ACK = 1'b1;
        tick();
        bus.INT_ACK = 1'b0;
        check("ack_req_low", 96'(bus.INT_REQ), 96'd0);
        check("ack_clr", 96'(bus.CLR_INT), 96'(exp_clr));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.INT_VECTOR  = '0;
        bus.ROM_FUNC_ID = '0;
        bus.ROM_PAYLOAD = '0;
        bus.ROM_CMD_LEN = '0;
        bus.INT_ACK     = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_req", 96'(bus.INT_REQ), 96'd0);
        check("rst_func", 96'(bus.INT_FUNC_ID), 96'd0);
        check("rst_payload", bus.INT_PAYLOAD, 96'd0);
        check("rst_len", 96'(bus.INT_CMD_LEN), 96'd0);
        check("rst_idx", 96'(bus.INT_IDX), 96'd0);
        check("rst_wake", 96'(bus.WAKEUP_REQ), 96'd0);
        check("rst_clr", 96'(bus.CLR_INT), 96'd0);
        check("rst_pend", 96'(bus.PENDING), 96'd0);
        rst = 1'b0;

        // Vector 0, length 1, latency and hold
        set_rom(0, 4'd2, 32'h00000201, 32'hAAAAAAAA, 32'hBBBBBBBB, 2'd1);
        pulse_vec(8'h01);
        check("t1_pend_k", 96'(bus.PENDING), 96'h01);
        check("t1_req_k", 96'(bus.INT_REQ), 96'd0);
        tick();
        check("t1_req_k1", 96'(bus.INT_REQ), 96'd0);
        tick();
        check("t1_req_k2", 96'(bus.INT_REQ), 96'd1);
        for (int i = 0; i < 5; i++) begin
            check("t1_hold_req", 96'(bus.INT_REQ), 96'd1);
            check("t1_func", 96'(bus.INT_FUNC_ID), 96'd2);
            check("t1_len", 96'(bus.INT_CMD_LEN), 96'd1);
            check("t1_payload", bus.INT_PAYLOAD, {32'h00000201, 64'h0});
            check("t1_idx", 96'(bus.INT_IDX), 96'd0);
            tick();
        end
        ack(8'h01);
        check("t1_pend_after", 96'(bus.PENDING), 96'h00);
        tick();
        check("t1_clr_pulse", 96'(bus.CLR_INT), 96'h00);

        // Two vectors at once: 4 before 7
        set_rom(4, 4'd4, 32'h44440000, 32'h44441111, 32'h44442222, 2'd3);
        set_rom(7, 4'd7, 32'h77770000, 32'h77771111, 32'h77772222, 2'd1);
        pulse_vec(8'h90);
        check("t2_pend", 96'(bus.PENDING), 96'h90);
        wait_req(6);
        check("t2_idx_a", 96'(bus.INT_IDX), 96'd4);
        check("t2_func_a", 96'(bus.INT_FUNC_ID), 96'd4);
        check("t2_payload_a", bus.INT_PAYLOAD, {32'h44440000, 32'h44441111, 32'h44442222});
        ack(8'h10);
        check("t2_pend_mid", 96'(bus.PENDING), 96'h80);
        tick();
        check("t2_gap_req", 96'(bus.INT_REQ), 96'd0);
        check("t2_gap_clr", 96'(bus.CLR_INT), 96'h00);
        wait_req(6);
        check("t2_idx_b", 96'(bus.INT_IDX), 96'd7);
        check("t2_payload_b", bus.INT_PAYLOAD, {32'h77770000, 64'h0});
        ack(8'h80);
        check("t2_pend_end", 96'(bus.PENDING), 96'h00);

        // Wake-only vector 7
        set_rom(7, 4'd7, 32'h77770000, 32'h77771111, 32'h77772222, 2'd0);
        pulse_vec(8'h80);
        check("t3_pend", 96'(bus.PENDING), 96'h80);
        tick();
        check("t3_wake_k1", 96'(bus.WAKEUP_REQ), 96'd0);
        tick();
        check("t3_wake", 96'(bus.WAKEUP_REQ), 96'd1);
        check("t3_clr", 96'(bus.CLR_INT), 96'h80);
        check("t3_req", 96'(bus.INT_REQ), 96'd0);
        check("t3_func", 96'(bus.INT_FUNC_ID), 96'd0);
        check("t3_pend_clr", 96'(bus.PENDING), 96'h00);
        tick();
        check("t3_wake_end", 96'(bus.WAKEUP_REQ), 96'd0);
        check("t3_clr_end", 96'(bus.CLR_INT), 96'h00);
        check("t3_req_end", 96'(bus.INT_REQ), 96'd0);

        // Stray ACK while idle is ignored
        bus.INT_ACK = 1'b1;
        tick();
        bus.INT_ACK = 1'b0;
        check("stray_ack_clr", 96'(bus.CLR_INT), 96'h00);
        check("stray_ack_req", 96'(bus.INT_REQ), 96'd0);

        // Length 2 masks word2; ROM changes during REQ are not seen
        set_rom(5, 4'd5, 32'h11111111, 32'h22222222, 32'h33333333, 2'd2);
        pulse_vec(8'h20);
        wait_req(6);
        check("t4_idx", 96'(bus.INT_IDX), 96'd5);
        check("t4_len", 96'(bus.INT_CMD_LEN), 96'd2);
        check("t4_payload", bus.INT_PAYLOAD, {32'h11111111, 32'h22222222, 32'h0});
        set_rom(5, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2'd3);
        tick();
        check("t4_func_stable", 96'(bus.INT_FUNC_ID), 96'd5);
        check("t4_payload_stable", bus.INT_PAYLOAD, {32'h11111111, 32'h22222222, 32'h0});
        ack(8'h20);

        // Re-pulse vector 3 alongside its ACK
        set_rom(3, 4'd3, 32'h30303030, 32'h31313131, 32'h32323232, 2'd1);
        pulse_vec(8'h08);
        wait_req(6);
        check("t5_idx", 96'(bus.INT_IDX), 96'd3);
        bus.INT_ACK    = 1'b1;
        bus.INT_VECTOR = 8'h08;
        tick();
        bus.INT_ACK    = 1'b0;
        bus.INT_VECTOR = 8'h00;
        check("t5_pend_kept", 96'(bus.PENDING), 96'h08);
        check("t5_clr", 96'(bus.CLR_INT), 96'h08);
        check("t5_req_low", 96'(bus.INT_REQ), 96'd0);
        wait_req(6);
        check("t5_idx_again", 96'(bus.INT_IDX), 96'd3);
        check("t5_payload_again", bus.INT_PAYLOAD, {32'h30303030, 64'h0});
        ack(8'h08);
        check("t5_pend_end", 96'(bus.PENDING), 96'h00);

        // Reset during REQ discards the command
        set_rom(1, 4'd1, 32'h10101010, 32'h0, 32'h0, 2'd1);
        set_rom(2, 4'd2, 32'h20202020, 32'h0, 32'h0, 2'd1);
        pulse_vec(8'h06);
        check("t6_pend", 96'(bus.PENDING), 96'h06);
        wait_req(6);
        check("t6_idx", 96'(bus.INT_IDX), 96'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.INT_ACK = 1'b1;
        check("t6_req", 96'(bus.INT_REQ), 96'd0);
        check("t6_func", 96'(bus.INT_FUNC_ID), 96'd0);
        check("t6_payload", bus.INT_PAYLOAD, 96'd0);
        check("t6_len", 96'(bus.INT_CMD_LEN), 96'd0);
        check("t6_idx_rst", 96'(bus.INT_IDX), 96'd0);
        check("t6_wake", 96'(bus.WAKEUP_REQ), 96'd0);
        check("t6_clr", 96'(bus.CLR_INT), 96'h00);
        check("t6_pend_rst", 96'(bus.PENDING), 96'h00);
        tick();
        bus.INT_ACK = 1'b0;
        check("t6_ack_clr", 96'(bus.CLR_INT), 96'h00);
        check("t6_ack_req", 96'(bus.INT_REQ), 96'd0);
        check("t6_ack_pend", 96'(bus.PENDING), 96'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_idle_req", 96'(bus.INT_REQ), 96'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/int_action_arbiter.md
Name: int_action_arbiter

Overview:
- Sits directly downstream of the interrupt action ROM, inside the layer controller.
- Latches interrupt request pulses into a pending register and selects the lowest-index pending interrupt.
- Captures that entry's function ID, 3-word payload and command length from the ROM, then presents it to the layer controller command engine over a REQ/ACK handshake.
- Length-0 entries are wake-up-only: they raise a wake pulse and are retired without the handshake.

Parameters:
- LC_INT_DEPTH, 8: number of interrupt vectors, 1..16.
- `FUNC_WIDTH` (4) and `DATA_WIDTH` (32) come from mbus_def; they are not parameters.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- INT_VECTOR  in  LC_INT_DEPTH  request pulses; bit i high in a cycle sets pending[i].
- ROM_FUNC_ID  in  FUNC_WIDTH*LC_INT_DEPTH  per-vector function ID (ROM int_func_id).
- ROM_PAYLOAD  in  DATA_WIDTH*3*LC_INT_DEPTH  per-vector payload; word0 is the MSB word.
- ROM_CMD_LEN  in  2*LC_INT_DEPTH  per-vector command length, 0..3.
- INT_REQ  out  1  command valid toward the layer controller.
- INT_FUNC_ID  out  FUNC_WIDTH  selected function ID.
- INT_PAYLOAD  out  DATA_WIDTH*3  selected payload, with unused words masked to 0.
- INT_CMD_LEN  out  2  selected command length.
- INT_IDX  out  4  index of the vector being serviced.
- INT_ACK  in  1  single-cycle accept from the layer controller.
- WAKEUP_REQ  out  1  single-cycle pulse for length-0 vectors.
- CLR_INT  out  LC_INT_DEPTH  one-hot, single-cycle pulse back to the source when a vector is retired.
- PENDING  out  LC_INT_DEPTH  current pending register.

Behaviour:
- Reset: pending=0, state=IDLE. All outputs are 0: INT_REQ, INT_FUNC_ID, INT_PAYLOAD, INT_CMD_LEN, INT_IDX, WAKEUP_REQ, CLR_INT, PENDING.
- Reset asserted mid-operation discards any in-flight command. No CLR_INT or WAKEUP_REQ pulse is issued for it.
- Pending update each edge: pending <= (pending & ~clr_mask) | INT_VECTOR.
  - clr_mask is the vector retired this cycle.
  - If a set and a clear hit the same bit in one cycle, the set wins and the vector is re-serviced later.
- FSM states: IDLE, LOAD, REQ, GAP.
- IDLE:
  - If pending != 0, register sel = lowest set index into INT_IDX and go to LOAD.
  - The selection is taken from the registered pending value; a bit that arrives in the same cycle is seen next cycle.
- LOAD:
  - Capture ROM fields[sel] into the output registers.
  - Mask payload words: len=1 keeps word0 only; len=2 keeps word0 and word1; len=3 keeps all three.
  - If len==0: pulse WAKEUP_REQ and CLR_INT[sel], clear pending[sel], outputs stay 0, go to GAP.
  - Otherwise go to REQ with INT_REQ=1.
- REQ:
  - INT_REQ and all command outputs are held stable until INT_ACK=1.
  - On INT_ACK: INT_REQ=0, pulse CLR_INT[sel], clear pending[sel], go to GAP.
  - No timeout.
  - New INT_VECTOR bits only accumulate in pending; no preemption.
- GAP: one idle cycle so the layer controller sees INT_REQ low, then IDLE.
- Latency: a bit sampled high at edge k into an idle FSM gives PENDING at k, LOAD at k+1, and INT_REQ high after edge k+2.
  - Back-to-back vectors are therefore issued at most one per 4 cycles plus the ACK wait.
- INT_ACK while not in REQ is ignored.
- ROM inputs are sampled only in LOAD; changes at other times have no effect.
- INT_VECTOR bits at or above LC_INT_DEPTH do not exist.
- Priority is fixed by index; lower index always wins, so starvation of high indices under continuous low-index traffic is accepted.

Decomposition:
- Shared package / mbus_def holds:
  - FUNC_WIDTH, DATA_WIDTH.
  - FSM state encodings: ST_IDLE, ST_LOAD, ST_REQ, ST_GAP.
  - Command-length constants CMD_LEN_WAKE=2'b00 through CMD_LEN_3=2'b11.
- One sub-module: int_prio_enc, a combinational lowest-set-bit encoder returning index and a valid flag. It is reusable by the MEM/RF arbiters.
- Field extraction from the flattened ROM buses stays inline via generate.

Test Plan:
- Reset, then INT_VECTOR=8'h01 for 1 cycle, ROM[0]=func 2, len 1, payload word0=32'h00000201 → INT_REQ high 3 cycles later.
  - INT_FUNC_ID=2, INT_CMD_LEN=1, INT_PAYLOAD={32'h00000201,64'h0}.
  - Hold INT_ACK low 5 cycles → outputs stable; ACK → CLR_INT=8'h01 for one cycle, PENDING=0.
- INT_VECTOR=8'h90 in one cycle → vector 4 serviced first (INT_IDX=4), then vector 7. Each retired with its own CLR_INT pulse, and INT_REQ low for ≥1 cycle between them.
- ROM[7] len=0, INT_VECTOR=8'h80 → WAKEUP_REQ and CLR_INT=8'h80 pulse together 2 cycles after the pending set. INT_REQ never rises.
- ROM[5] len=2 with payload words A,B,C nonzero → INT_PAYLOAD={A,B,32'h0}.
- Re-pulse INT_VECTOR bit 3 in the same cycle as INT_ACK for vector 3 → PENDING[3] stays 1 and vector 3 is issued again.
- Assert RESET while in REQ with PENDING=8'h06 → next cycle all outputs 0, PENDING=0, no CLR_INT pulse. A subsequent ACK is ignored.
